// File: rtl/match_ctrl_if.sv
// Signal bundle between the match controller and the game datapath:
// button/collision events in, state, scores and ball control out.
interface match_ctrl_if;
    logic       start;
    logic       frame_tick;
    logic       miss_left;
    logic       miss_right;
    logic [2:0] state;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic       score_pulse_left;
    logic       score_pulse_right;
    logic       ball_enable;
    logic       ball_reset;
    logic       serve_dir;
    logic       game_over;
    logic       winner;

    modport master (
        output start, frame_tick, miss_left, miss_right,
        input  state, score_left, score_right, score_pulse_left, score_pulse_right,
               ball_enable, ball_reset, serve_dir, game_over, winner
    );

    modport slave (
        input  start, frame_tick, miss_left, miss_right,
        output state, score_left, score_right, score_pulse_left, score_pulse_right,
               ball_enable, ball_reset, serve_dir, game_over, winner
    );
endinterface

// File: rtl/match_ctrl.sv
// Pong match sequencer: IDLE -> SERVE -> PLAY -> POINT/OVER, with frame-timed
// serve and point pauses, score keeping and fully registered outputs.
module match_ctrl #(
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90
) (
    input  logic         clk,
    input  logic         reset,
    match_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic [3:0] WIN_PTS    = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES);
    localparam logic [7:0] POINT_LOAD = 8'(POINT_FRAMES);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] score_l_q, score_l_d;
    logic [3:0] score_r_q, score_r_d;
    logic       pulse_l_q, pulse_l_d;
    logic       pulse_r_q, pulse_r_d;
    logic       serve_dir_q, serve_dir_d;
    logic       winner_q, winner_d;
    logic       ball_enable_q, ball_reset_q, game_over_q;
    logic       start_q;
    logic       start_evt;

    assign start_evt = bus.start & ~start_q;

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        pulse_l_d   = 1'b0;
        pulse_r_d   = 1'b0;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;

        case (state_q)
            IDLE: begin
                if (start_evt) begin
                    state_d   = SERVE;
                    score_l_d = '0;
                    score_r_d = '0;
                    cnt_d     = SERVE_LOAD;
                end
            end
            SERVE: begin
                if (bus.frame_tick) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = PLAY;
                end
            end
            PLAY: begin
                if (bus.miss_left && bus.miss_right) begin
                    // Both paddles missed in one clock: replay the point.
                    state_d = POINT;
                    cnt_d   = POINT_LOAD;
                end else if (bus.miss_right) begin
                    score_l_d   = score_l_q + 4'd1;
                    pulse_l_d   = 1'b1;
                    serve_dir_d = 1'b0;
                    if (score_l_q + 4'd1 == WIN_PTS) begin
                        state_d  = OVER;
                        winner_d = 1'b0;
                    end else begin
                        state_d = POINT;
                        cnt_d   = POINT_LOAD;
                    end
                end else if (bus.miss_left) begin
                    score_r_d   = score_r_q + 4'd1;
                    pulse_r_d   = 1'b1;
                    serve_dir_d = 1'b1;
                    if (score_r_q + 4'd1 == WIN_PTS) begin
                        state_d  = OVER;
                        winner_d = 1'b1;
                    end else begin
                        state_d = POINT;
                        cnt_d   = POINT_LOAD;
                    end
                end
            end
            POINT: begin
                if (bus.frame_tick) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = SERVE;
                        cnt_d   = SERVE_LOAD;
                    end
                end
            end
            OVER: begin
                if (start_evt) begin
                    state_d     = SERVE;
                    score_l_d   = '0;
                    score_r_d   = '0;
                    serve_dir_d = 1'b0;
                    cnt_d       = SERVE_LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            score_l_q     <= '0;
            score_r_q     <= '0;
            pulse_l_q     <= 1'b0;
            pulse_r_q     <= 1'b0;
            serve_dir_q   <= 1'b0;
            winner_q      <= 1'b0;
            ball_enable_q <= 1'b0;
            ball_reset_q  <= 1'b0;
            game_over_q   <= 1'b0;
            start_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            score_l_q     <= score_l_d;
            score_r_q     <= score_r_d;
            pulse_l_q     <= pulse_l_d;
            pulse_r_q     <= pulse_r_d;
            serve_dir_q   <= serve_dir_d;
            winner_q      <= winner_d;
            // Decodes come from the next state so they line up with the state output.
            ball_enable_q <= (state_d == PLAY);
            ball_reset_q  <= (state_d == SERVE);
            game_over_q   <= (state_d == OVER);
            start_q       <= bus.start;
        end
    end

    assign bus.state             = state_q;
    assign bus.score_left        = score_l_q;
    assign bus.score_right       = score_r_q;
    assign bus.score_pulse_left  = pulse_l_q;
    assign bus.score_pulse_right = pulse_r_q;
    assign bus.ball_enable       = ball_enable_q;
    assign bus.ball_reset        = ball_reset_q;
    assign bus.serve_dir         = serve_dir_q;
    assign bus.game_over         = game_over_q;
    assign bus.winner            = winner_q;

endmodule
